// File: rtl/uart_rx_if.sv
// AXI4-Stream style word channel carrying received UART data.
// The receiver drives tdata/tvalid and the consumer drives tready.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling at prescale*8 clocks per bit,
// one-word AXI-Stream output buffer with framing/overrun pulses.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_rx_if.master   output_axis,
    input  logic        rxd,
    output logic        busy,
    output logic        overrun_error,
    output logic        frame_error,
    input  logic [15:0] prescale
);
    localparam int unsigned CNT_W = 19;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE_ARM,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                state;
    logic                  rxd_meta;
    logic                  rxd_s;
    logic [15:0]           p_cap;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;

    logic [15:0]           p_in_c;
    logic [CNT_W-1:0]      half_c;
    logic [CNT_W-1:0]      full_c;

    // Zero prescale behaves as one; half period is 4P-1, full period 8P-1 (from captured P)
    assign p_in_c = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half_c = {1'b0, p_in_c, 2'b00} - CNT_W'(1);
    assign full_c = {p_cap, 3'b000} - CNT_W'(1);

    assign output_axis.tdata  = tdata_q;
    assign output_axis.tvalid = tvalid_q;

    // Two-flop synchronizer, idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE_ARM;
            p_cap         <= 16'd1;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            busy          <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            if (tvalid_q && output_axis.tready) begin
                tvalid_q <= 1'b0;
            end

            case (state)
                S_IDLE_ARM: begin
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!rxd_s) begin
                        p_cap <= p_in_c;
                        cnt   <= half_c;
                        busy  <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (rxd_s) begin
                        // Start bit gone by mid-period: treat as a glitch
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt     <= full_c;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shreg   <= {rxd_s, shreg[DATA_WIDTH-1:1]};
                        cnt     <= full_c;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        busy <= 1'b0;
                        if (rxd_s) begin
                            // New word wins over the pending one; flag if it was never taken
                            tdata_q  <= shreg;
                            tvalid_q <= 1'b1;
                            if (tvalid_q && !output_axis.tready) begin
                                overrun_error <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= S_IDLE_ARM;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE_ARM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed framing cases plus randomized frames
// compared against an expected-word queue.
module tb_uart_rx;
    localparam int unsigned DW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale;

    uart_rx_if #(.DATA_WIDTH(DW)) axis_if ();

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .output_axis   (axis_if.master),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge, away from DUT updates
    logic [DW-1:0] got_words [0:511];
    int   got_n     = 0;
    int   busy_cyc  = 0;
    int   valid_cyc = 0;
    int   fe_cnt    = 0;
    int   oe_cnt    = 0;
    int   both_cnt  = 0;
    int   rise_cyc  = -1;
    logic prev_v    = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (axis_if.tvalid && axis_if.tready) begin
                got_words[got_n] <= axis_if.tdata;
                got_n <= got_n + 1;
            end
            if (axis_if.tvalid) valid_cyc <= valid_cyc + 1;
            if (axis_if.tvalid && !prev_v) rise_cyc <= cyc;
            prev_v <= axis_if.tvalid;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (frame_error) fe_cnt <= fe_cnt + 1;
            if (overrun_error) oe_cnt <= oe_cnt + 1;
            if (frame_error && overrun_error) both_cnt <= both_cnt + 1;
        end else begin
            prev_v <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (rdy_mode == 1) axis_if.tready = ~axis_if.tready;
        else if (rdy_mode == 2) axis_if.tready = 1'($urandom_range(0, 1));
    endtask

    function automatic int eff_p();
        return (prescale == 16'd0) ? 1 : int'(prescale);
    endfunction

    // Line-level transmitter: start, LSB-first data, one stop bit of the given level
    task automatic send_frame(input logic [DW-1:0] d, input logic stop);
        int p;
        p = eff_p();
        rxd = 1'b0;
        repeat (8 * p) tick();
        for (int i = 0; i < int'(DW); i++) begin
            rxd = d[i];
            repeat (8 * p) tick();
        end
        rxd = stop;
        repeat (8 * p) tick();
    endtask

    // Reference model: words that must come out, in order
    logic [DW-1:0] exp_q[$];
    int rd = 0;

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 32'(got_n - rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rd < got_n) begin
            check({tag, "_word"}, 32'(got_words[rd]), 32'(exp_q.pop_front()));
            rd++;
        end
        rd = got_n;
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, b0, v0, f0, o0, p;
        logic [DW-1:0] d;

        rst_n = 1'b0;
        rxd = 1'b1;
        prescale = 16'd1;
        axis_if.tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", 32'(axis_if.tvalid), 0);
        check("rst_tdata", 32'(axis_if.tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fe", 32'(frame_error), 0);
        check("rst_oe", 32'(overrun_error), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // P=1 single frame timing
        prescale = 16'd1;
        t0 = cyc; b0 = busy_cyc; v0 = valid_cyc; f0 = fe_cnt; o0 = oe_cnt;
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        repeat (10) tick();
        check("a5_rise", 32'(rise_cyc), 32'(t0 + 3 + 4 + 8 * (DW + 1)));
        check("a5_busy", 32'(busy_cyc - b0), 32'(4 + 8 * (DW + 1)));
        check("a5_valid_len", 32'(valid_cyc - v0), 1);
        check("a5_errs", 32'((fe_cnt - f0) + (oe_cnt - o0)), 0);
        compare_q("a5");

        // P=2 glitch: 6 clocks low is rejected at the start sample
        prescale = 16'd2;
        b0 = busy_cyc; v0 = valid_cyc; f0 = fe_cnt; o0 = oe_cnt;
        rxd = 1'b0;
        repeat (6) tick();
        rxd = 1'b1;
        repeat (30) tick();
        check("glitch_busy", 32'(busy_cyc - b0), 8);
        check("glitch_valid", 32'(valid_cyc - v0), 0);
        check("glitch_errs", 32'((fe_cnt - f0) + (oe_cnt - o0)), 0);
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        repeat (10) tick();
        compare_q("glitch");

        // P=1 break: stop bit low, line held low, then recovery
        prescale = 16'd1;
        f0 = fe_cnt; v0 = valid_cyc;
        send_frame(8'h00, 1'b0);
        b0 = busy_cyc;
        repeat (40) tick();
        check("break_fe", 32'(fe_cnt - f0), 1);
        check("break_tvalid", 32'(axis_if.tvalid), 0);
        check("break_valid", 32'(valid_cyc - v0), 0);
        check("break_rearm", 32'(busy_cyc - b0), 0);
        rxd = 1'b1;
        repeat (10) tick();
        send_frame(8'h81, 1'b1);
        exp_q.push_back(8'h81);
        repeat (10) tick();
        compare_q("break");

        // Overrun with tready low
        axis_if.tready = 1'b0;
        o0 = oe_cnt; f0 = fe_cnt;
        send_frame(8'h12, 1'b1);
        repeat (10) tick();
        check("ovr_first_valid", 32'(axis_if.tvalid), 1);
        check("ovr_first_data", 32'(axis_if.tdata), 32'h12);
        send_frame(8'h34, 1'b1);
        repeat (10) tick();
        check("ovr_pulse", 32'(oe_cnt - o0), 1);
        check("ovr_fe", 32'(fe_cnt - f0), 0);
        check("ovr_valid", 32'(axis_if.tvalid), 1);
        check("ovr_data", 32'(axis_if.tdata), 32'h34);
        axis_if.tready = 1'b1;
        tick();
        axis_if.tready = 1'b0;
        repeat (3) tick();
        check("ovr_drained", 32'(axis_if.tvalid), 0);
        exp_q.push_back(8'h34);
        compare_q("ovr");

        // P=3 reset in the middle of data bit 4 of 0xFF
        prescale = 16'd3;
        axis_if.tready = 1'b1;
        rxd = 1'b0;
        repeat (24) tick();
        rxd = 1'b1;
        repeat (4 * 24 + 12) tick();
        check("rst_mid_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_tvalid", 32'(axis_if.tvalid), 0);
        check("rst_mid_tdata", 32'(axis_if.tdata), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        f0 = fe_cnt; o0 = oe_cnt;
        send_frame(8'h5A, 1'b1);
        exp_q.push_back(8'h5A);
        repeat (10) tick();
        check("rst_mid_errs", 32'((fe_cnt - f0) + (oe_cnt - o0)), 0);
        compare_q("rst_mid");

        // Randomized frames with random prescale (including 0) and random tready
        for (int r = 0; r < 3; r++) begin
            prescale = 16'($urandom_range(0, 4));
            p = eff_p();
            f0 = fe_cnt; o0 = oe_cnt;
            rdy_mode = 2;
            for (int i = 0; i < 8; i++) begin
                d = DW'($urandom);
                send_frame(d, 1'b1);
                exp_q.push_back(d);
                repeat (8 * p * $urandom_range(0, 2)) tick();
            end
            repeat (30) tick();
            rdy_mode = 0;
            axis_if.tready = 1'b1;
            repeat (5) tick();
            check("rand_errs", 32'((fe_cnt - f0) + (oe_cnt - o0)), 0);
            compare_q("rand");
        end

        // Back-to-back stream at P=3 with tready toggling every cycle
        prescale = 16'd3;
        f0 = fe_cnt; o0 = oe_cnt;
        rdy_mode = 1;
        for (int i = 0; i < 64; i++) begin
            d = DW'($urandom);
            send_frame(d, 1'b1);
            exp_q.push_back(d);
        end
        repeat (20) tick();
        rdy_mode = 0;
        axis_if.tready = 1'b1;
        repeat (5) tick();
        check("loop_errs", 32'((fe_cnt - f0) + (oe_cnt - o0)), 0);
        compare_q("loop");

        check("no_dual_error", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that pairs with the team's AXI4-Stream UART transmitter. It synchronizes the `rxd` line and detects start bits. It samples each bit at mid-period using the same `prescale` convention as the transmitter (one bit = `prescale`×8 clocks). Each received word is presented on an AXI4-Stream master port with one-word output buffering, and framing and overrun conditions are reported as single-cycle pulses.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame. Frames carry no parity and one stop bit.
- `clk`  in  1: sole clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `output_axis_tdata`  out  DATA_WIDTH: received word, LSB first on the line.
- `output_axis_tvalid`  out  1: word valid.
- `output_axis_tready`  in  1: downstream accepts.
- `rxd`  in  1: serial input. It is asynchronous to `clk` and idles high.
- `busy`  out  1: high while a frame is in progress (start detect through stop sample).
- `overrun_error`  out  1: one-cycle pulse when a word completes while the previous word is unaccepted.
- `frame_error`  out  1: one-cycle pulse when the stop bit samples low.
- `prescale`  in  16: bit period is `prescale`×8 clocks. A value of 0 is treated as 1. The value is captured at start detect and held for the whole frame.

## Operation
- Input path: a two-flop synchronizer (reset value 1) produces `rxd_s`. All decisions use `rxd_s` only.
- States:
  - IDLE_ARM: wait for `rxd_s`=1, then go to IDLE.
  - IDLE: on `rxd_s`=0, capture P=max(`prescale`,1), load the 19-bit down-counter with 4P−1, set `busy`, and go to START.
  - START: when the counter reaches 0, sample `rxd_s`.
    - If it is 1, treat it as a glitch: clear `busy` and go to IDLE. No output and no error.
    - If it is 0, load the counter with 8P−1, clear the bit count, and go to DATA.
  - DATA: at each counter zero, shift `rxd_s` into the MSB of the shift register (right shift, so LSB-first ends aligned) and reload 8P−1. After DATA_WIDTH samples, go to STOP.
  - STOP: when the counter reaches 0, sample `rxd_s`, clear `busy`, and apply one of the following:
    - If the sample is 1 and `tvalid`=0, or `tvalid`=1 with `tready`=1 this cycle: load `tdata`, set `tvalid`, and go to IDLE.
    - If the sample is 1, `tvalid`=1 and `tready`=0: overwrite `tdata` with the new word, keep `tvalid`=1, pulse `overrun_error`, and go to IDLE.
    - If the sample is 0: pulse `frame_error`, discard the word, leave `tdata`/`tvalid` untouched, and go to IDLE_ARM.
- Output handshake: `tvalid` clears on a cycle with `tvalid`&&`tready`, unless a new word loads in that same cycle; in that case `tvalid` stays 1 with the new data.
- Width rules:
  - The counter is 19 bits; 8P−1 fits for P≤65535.
  - The bit counter is wide enough for DATA_WIDTH (4 bits for DATA_WIDTH≤15).
- Receiving does not depend on `tready`. The line is never back-pressured.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `busy`=0, `overrun_error`=0, `frame_error`=0; synchronizer=1; state=IDLE_ARM.
- Asynchronous assert; the first state change happens on the first `clk` edge after deassertion.
- Let E be the clock edge at which IDLE sees `rxd_s`=0. `rxd_s` lags `rxd` by 2 clocks.
- Sample k is taken at E + 4P + 8P·k, where k=0 is the start bit, 1..DATA_WIDTH are the data bits, and DATA_WIDTH+1 is the stop bit.
- `tvalid` (or an error pulse) is visible in the cycle after the stop-sample edge. It is registered, so latency is zero extra cycles beyond that edge.
- `busy` is high from the cycle after E through the stop-sample edge. It is low in the cycle where `tvalid` first rises.
- Back-to-back frames: a start bit whose falling edge arrives 4P clocks after the stop sample (a standard transmitter's stop end) is detected. IDLE is re-entered in the cycle immediately after the stop sample.
- Reset mid-frame: the partial word is dropped and all outputs return to their reset values. The receiver resumes only after `rxd_s` is seen high (IDLE_ARM).
- `frame_error` and `overrun_error` never assert in the same cycle.

## Test plan
- P=1, `tready`=1, transmit 0xA5 → `tvalid` high exactly one cycle with `tdata`=0xA5 at E+76+1; no error pulses; `busy` high for 76 cycles.
- P=2, `rxd` low for 6 clocks then high → no `tvalid`, no errors; `busy` falls after the start sample at E+8; the next valid frame 0x3C is received correctly.
- P=1, frame 0x00 with the line held low through the stop bit (break) → `frame_error` one-cycle pulse, `tvalid` stays 0; no further frames until `rxd` goes high; then 0x81 is received.
- P=1, `tready`=0, send 0x12 then 0x34 → `tvalid`=1 with `tdata`=0x12, then `overrun_error` pulses once and `tdata`=0x34 with `tvalid` still 1; raising `tready` clears `tvalid` after one transfer.
- P=3, assert `rst_n`=0 mid data bit 4 of 0xFF for 2 cycles → all outputs reset immediately; the subsequent 0x5A is received with no error.
- Loopback against the team transmitter at P=3, 64 random words back-to-back, with `tready` toggling every cycle → every word is received in order, with zero errors.
